mcu_bus_transceiver: RTL and testbench

Parametrised, bidirectional successor to the MCU bus interface. Samples the asynchronous MCU parallel bus (strobe, data, command/data flag) into the `system_clock` domain through configurable synchronizers. Buffers received words in an RX FIFO, and drives words back to the MCU under a turnaround state machine. Sits between the MCU pins and the command decoder / register file of the RAMDAC.

---
 rtl/mcu_bus_transceiver.sv | 138 +++++++++++++
 tb/tb_mcu_bus_transceiver.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mcu_bus_transceiver.sv
// Bidirectional MCU parallel-bus transceiver: synchronizes the async strobe/data into
// system_clock, queues received words in an RX FIFO and drives readback words under a turnaround FSM.
module mcu_bus_transceiver #(
    parameter int DATA_WIDTH    = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic                  system_clock,
    input  logic                  system_reset_n,
    input  logic                  bus_clock,
    input  logic [DATA_WIDTH-1:0] bus_data_in,
    input  logic                  bus_command_data_in,
    output logic [DATA_WIDTH-1:0] bus_data_out,
    output logic                  bus_command_data_out,
    output logic                  bus_direction,
    output logic                  rx_valid,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_command_data,
    input  logic                  rx_ready,
    input  logic                  tx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_command_data,
    output logic                  tx_ready,
    output logic                  rx_overflow,
    input  logic                  overflow_clear
);

    localparam int AW = $clog2(RX_FIFO_DEPTH);

    typedef struct packed {
        logic                  cmd;
        logic [DATA_WIDTH-1:0] data;
    } word_t;

    typedef enum logic [1:0] {ST_INPUT, ST_DRIVE, ST_DRAIN} state_t;

    state_t                  state;
    logic [SYNC_STAGES-1:0]  strobe_sync;
    word_t [SYNC_STAGES-1:0] word_sync;
    logic                    strobe_prev;
    logic                    strobe_edge;

    word_t                   fifo_mem [RX_FIFO_DEPTH];
    logic [AW:0]             wr_ptr, rd_ptr;
    logic                    fifo_empty, fifo_full;
    logic                    push, pop, drop, tx_accept, in_input;

    // Strobe and word share identical chains so the data is aligned with the edge.
    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            strobe_sync <= '0;
            word_sync   <= '0;
            strobe_prev <= 1'b0;
        end else begin
            strobe_sync[0] <= bus_clock;
            word_sync[0]   <= word_t'{cmd: bus_command_data_in, data: bus_data_in};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                strobe_sync[i] <= strobe_sync[i-1];
                word_sync[i]   <= word_sync[i-1];
            end
            strobe_prev <= strobe_sync[SYNC_STAGES-1];
        end
    end

    assign strobe_edge = strobe_sync[SYNC_STAGES-1] & ~strobe_prev;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign in_input   = (state == ST_INPUT);
    assign pop        = rx_ready & ~fifo_empty;
    assign push       = in_input & strobe_edge & (~fifo_full | pop);
    assign drop       = in_input & strobe_edge & fifo_full & ~pop;

    assign rx_valid        = ~fifo_empty;
    assign rx_data         = fifo_mem[rd_ptr[AW-1:0]].data;
    assign rx_command_data = fifo_mem[rd_ptr[AW-1:0]].cmd;

    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            rx_overflow <= 1'b0;
            for (int i = 0; i < RX_FIFO_DEPTH; i++) fifo_mem[i] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr[AW-1:0]] <= word_sync[SYNC_STAGES-1];
                wr_ptr                   <= wr_ptr + (AW+1)'(1);
            end
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
            if (drop)                rx_overflow <= 1'b1;
            else if (overflow_clear) rx_overflow <= 1'b0;
        end
    end

    // An RX edge always wins over a TX request in INPUT, so pending RX words drain first.
    always_comb begin
        tx_ready = 1'b0;
        case (state)
            ST_INPUT: tx_ready = fifo_empty & ~strobe_edge;
            ST_DRAIN: tx_ready = 1'b1;
            default:  tx_ready = 1'b0;
        endcase
    end

    assign tx_accept = tx_valid & tx_ready;

    always_ff @(posedge system_clock or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state                <= ST_INPUT;
            bus_direction        <= 1'b0;
            bus_data_out         <= '0;
            bus_command_data_out <= 1'b0;
        end else begin
            case (state)
                ST_INPUT: if (tx_accept) begin
                    bus_data_out         <= tx_data;
                    bus_command_data_out <= tx_command_data;
                    bus_direction        <= 1'b1;
                    state                <= ST_DRIVE;
                end
                ST_DRIVE: if (strobe_edge) state <= ST_DRAIN;
                ST_DRAIN: if (tx_accept) begin
                    bus_data_out         <= tx_data;
                    bus_command_data_out <= tx_command_data;
                    state                <= ST_DRIVE;
                end else begin
                    bus_direction <= 1'b0;
                    state         <= ST_INPUT;
                end
                default: begin
                    bus_direction <= 1'b0;
                    state         <= ST_INPUT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcu_bus_transceiver.sv
// Directed bench for mcu_bus_transceiver (DATA_WIDTH=8, SYNC_STAGES=2, RX_FIFO_DEPTH=4).
module tb_mcu_bus_transceiver;
    logic       system_clock = 1'b0;
    logic       system_reset_n = 1'b0;
    logic       bus_clock = 1'b0;
    logic [7:0] bus_data_in = '0;
    logic       bus_command_data_in = 1'b0;
    logic [7:0] bus_data_out;
    logic       bus_command_data_out, bus_direction;
    logic       rx_valid, rx_command_data, tx_ready, rx_overflow;
    logic [7:0] rx_data;
    logic       rx_ready = 1'b0, tx_valid = 1'b0, tx_command_data = 1'b0, overflow_clear = 1'b0;
    logic [7:0] tx_data = '0;

    int n_cmp = 0;
    int n_fail = 0;

    mcu_bus_transceiver #(.DATA_WIDTH(8), .SYNC_STAGES(2), .RX_FIFO_DEPTH(4)) dut (
        .system_clock(system_clock), .system_reset_n(system_reset_n),
        .bus_clock(bus_clock), .bus_data_in(bus_data_in), .bus_command_data_in(bus_command_data_in),
        .bus_data_out(bus_data_out), .bus_command_data_out(bus_command_data_out),
        .bus_direction(bus_direction), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_command_data(rx_command_data), .rx_ready(rx_ready), .tx_valid(tx_valid),
        .tx_data(tx_data), .tx_command_data(tx_command_data), .tx_ready(tx_ready),
        .rx_overflow(rx_overflow), .overflow_clear(overflow_clear)
    );

    always #5 system_clock = ~system_clock;

    task automatic tick();
        @(posedge system_clock);
        #1;
    endtask

    // Full MCU write cycle: strobe high 3 clocks, low 3 clocks; word is queued by the third high tick.
    task automatic mcu_write(input logic [7:0] d, input logic f);
        bus_data_in = d; bus_command_data_in = f; bus_clock = 1'b1;
        repeat (3) tick();
        bus_clock = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (bus_direction !== 1'b0) begin n_fail++; $display("FAIL reset_dir: got %b want 0", bus_direction); end
        n_cmp++; if (bus_data_out !== 8'h00) begin n_fail++; $display("FAIL reset_dout: got %h want 00", bus_data_out); end
        n_cmp++; if (bus_command_data_out !== 1'b0) begin n_fail++; $display("FAIL reset_cdout: got %b want 0", bus_command_data_out); end
        n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rxv: got %b want 0", rx_valid); end
        n_cmp++; if (rx_overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", rx_overflow); end
        n_cmp++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL reset_txr: got %b want 1", tx_ready); end
        repeat (2) tick();
        system_reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single_write();
        bus_data_in = 8'hA5; bus_command_data_in = 1'b1; bus_clock = 1'b1;
        tick();
        n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL sw_lat_k: got %b want 0", rx_valid); end
        tick();
        n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL sw_lat_k1: got %b want 0", rx_valid); end
        tick();
        n_cmp++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL sw_lat_k2: got %b want 1", rx_valid); end
        n_cmp++; if (rx_data !== 8'hA5) begin n_fail++; $display("FAIL sw_data: got %h want a5", rx_data); end
        n_cmp++; if (rx_command_data !== 1'b1) begin n_fail++; $display("FAIL sw_flag: got %b want 1", rx_command_data); end
        n_cmp++; if (bus_direction !== 1'b0) begin n_fail++; $display("FAIL sw_dir: got %b want 0", bus_direction); end
        bus_clock = 1'b0;
        repeat (3) tick();
        rx_ready = 1'b1; tick(); rx_ready = 1'b0;
        n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL sw_pop: got %b want 0", rx_valid); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp;
        for (int i = 1; i <= 5; i++) mcu_write(8'(i), 1'b0);
        n_cmp++; if (rx_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set: got %b want 1", rx_overflow); end
        overflow_clear = 1'b1; tick(); overflow_clear = 1'b0;
        n_cmp++; if (rx_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b want 0", rx_overflow); end
        for (int i = 1; i <= 4; i++) begin
            exp = 8'(i);
            rx_ready = 1'b1; #1;
            n_cmp++; if (rx_data !== exp) begin n_fail++; $display("FAIL ovf_pop%0d: got %h want %h", i, rx_data, exp); end
            tick();
        end
        rx_ready = 1'b0;
        n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %b want 0", rx_valid); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp;
        for (int i = 0; i < 4; i++) mcu_write(8'h11 + 8'(i), 1'b0);
        bus_data_in = 8'h15; bus_clock = 1'b1;
        tick(); tick();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        n_cmp++; if (rx_overflow !== 1'b0) begin n_fail++; $display("FAIL fpp_ovf: got %b want 0", rx_overflow); end
        bus_clock = 1'b0;
        repeat (3) tick();
        for (int i = 0; i < 4; i++) begin
            exp = 8'h12 + 8'(i);
            rx_ready = 1'b1; #1;
            n_cmp++; if (rx_data !== exp) begin n_fail++; $display("FAIL fpp_pop%0d: got %h want %h", i, rx_data, exp); end
            tick();
        end
        rx_ready = 1'b0;
        n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL fpp_count: got %b want 0", rx_valid); end
    endtask

    task automatic test_back_to_back();
        tx_valid = 1'b1; tx_data = 8'h3C; tx_command_data = 1'b1; #1;
        n_cmp++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_txr_in: got %b want 1", tx_ready); end
        tick();
        tx_data = 8'hC3; tx_command_data = 1'b0;
        n_cmp++; if (bus_direction !== 1'b1) begin n_fail++; $display("FAIL b2b_dir1: got %b want 1", bus_direction); end
        n_cmp++; if (bus_data_out !== 8'h3C || bus_command_data_out !== 1'b1) begin n_fail++; $display("FAIL b2b_word1: got %h/%b want 3c/1", bus_data_out, bus_command_data_out); end
        n_cmp++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_txr_drive: got %b want 0", tx_ready); end
        tick();
        bus_clock = 1'b1;
        tick(); tick();
        n_cmp++; if (bus_data_out !== 8'h3C) begin n_fail++; $display("FAIL b2b_hold1: got %h want 3c", bus_data_out); end
        tick();
        n_cmp++; if (tx_ready !== 1'b1 || bus_direction !== 1'b1) begin n_fail++; $display("FAIL b2b_drain: got txr=%b dir=%b want 1/1", tx_ready, bus_direction); end
        tick();
        tx_valid = 1'b0;
        n_cmp++; if (bus_data_out !== 8'hC3 || bus_direction !== 1'b1) begin n_fail++; $display("FAIL b2b_word2: got %h dir=%b want c3/1", bus_data_out, bus_direction); end
        bus_clock = 1'b0;
        repeat (3) tick();
        bus_clock = 1'b1;
        repeat (3) tick();
        n_cmp++; if (bus_direction !== 1'b1) begin n_fail++; $display("FAIL b2b_drain2_dir: got %b want 1", bus_direction); end
        tick();
        n_cmp++; if (bus_direction !== 1'b0) begin n_fail++; $display("FAIL b2b_back_input: got %b want 0", bus_direction); end
        n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_no_rx: got %b want 0", rx_valid); end
        bus_clock = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_collision();
        bus_data_in = 8'h77; bus_command_data_in = 1'b1; bus_clock = 1'b1;
        tick(); tick();
        tx_valid = 1'b1; tx_data = 8'h99; tx_command_data = 1'b0; #1;
        n_cmp++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL col_txr_edge: got %b want 0", tx_ready); end
        tick();
        n_cmp++; if (rx_valid !== 1'b1 || rx_data !== 8'h77) begin n_fail++; $display("FAIL col_rx: got v=%b d=%h want 1/77", rx_valid, rx_data); end
        n_cmp++; if (tx_ready !== 1'b0) begin n_fail++; $display("FAIL col_txr_nonempty: got %b want 0", tx_ready); end
        bus_clock = 1'b0;
        repeat (3) tick();
        n_cmp++; if (bus_direction !== 1'b0) begin n_fail++; $display("FAIL col_dir_wait: got %b want 0", bus_direction); end
        rx_ready = 1'b1; tick(); rx_ready = 1'b0;
        n_cmp++; if (tx_ready !== 1'b1) begin n_fail++; $display("FAIL col_txr_drained: got %b want 1", tx_ready); end
        tick();
        tx_valid = 1'b0;
        n_cmp++; if (bus_direction !== 1'b1 || bus_data_out !== 8'h99) begin n_fail++; $display("FAIL col_tx_sent: got dir=%b d=%h want 1/99", bus_direction, bus_data_out); end
    endtask

    task automatic test_async_reset();
        #3;
        system_reset_n = 1'b0;
        #1;
        n_cmp++; if (bus_direction !== 1'b0) begin n_fail++; $display("FAIL ar_dir: got %b want 0", bus_direction); end
        n_cmp++; if (bus_data_out !== 8'h00) begin n_fail++; $display("FAIL ar_dout: got %h want 00", bus_data_out); end
        n_cmp++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ar_rxv: got %b want 0", rx_valid); end
        tick();
        system_reset_n = 1'b1;
        tick();
        mcu_write(8'h5A, 1'b0);
        n_cmp++; if (rx_valid !== 1'b1 || rx_data !== 8'h5A || rx_command_data !== 1'b0) begin n_fail++; $display("FAIL ar_rx_after: got v=%b d=%h f=%b want 1/5a/0", rx_valid, rx_data, rx_command_data); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_overflow();
        test_full_push_pop();
        test_back_to_back();
        test_collision();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
